// File: rtl/pe_wb_packer.sv
// ---------------------------------------------------------------------------
// pe_wb_packer
//   Packs a stream of right-justified PE result elements into 32-bit
//   little-endian writeback words for a vector register. Element width
//   (EEW = vsew + widening) is latched at start; each completed word is
//   presented with byte enables and its word index within vd.
//
// Ports
//   clk, n_reset                 clock, synchronous active-low reset
//   start, vl, vsew, widening    instruction request (sampled in IDLE only)
//   in_valid/in_ready/in_data    PE element stream, one element per beat
//   out_valid/out_ready          packed-word handshake
//   out_data/out_be/out_idx      packed word, byte enables, word index
//   busy, done, err              not-IDLE, completion pulse, illegal EEW
// ---------------------------------------------------------------------------
module pe_wb_packer #(
  parameter int VL_W = 7
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            start,
  input  logic [VL_W-1:0] vl,
  input  logic [1:0]      vsew,
  input  logic [1:0]      widening,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_data,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [31:0]     out_data,
  output logic [3:0]      out_be,
  output logic [VL_W-1:0] out_idx,
  output logic            busy,
  output logic            done,
  output logic            err
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_PACK  = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  logic [1:0]      state_q, state_d;
  logic [1:0]      eew_q, eew_d;
  logic [VL_W-1:0] vl_q, vl_d;
  logic [VL_W-1:0] cnt_q, cnt_d;
  logic [31:0]     pack_data_q, pack_data_d;
  logic [3:0]      pack_be_q, pack_be_d;
  logic            out_valid_q, out_valid_d;
  logic [31:0]     out_data_q, out_data_d;
  logic [3:0]      out_be_q, out_be_d;
  logic [VL_W-1:0] out_idx_q, out_idx_d;
  logic            done_q, done_d;
  logic            err_q, err_d;

  // Request decode: EEW can reach 6, so it needs a third bit to detect > 2.
  logic [2:0]      eew_sum;
  logic            eew_illegal;

  // Per-element lane placement derived from the latched EEW.
  logic [1:0]      byte_off;
  logic            slot_last;
  logic            last_elem;
  logic [31:0]     elem_mask;
  logic [3:0]      elem_be;
  logic [VL_W-1:0] word_idx;
  logic [31:0]     merged_data;
  logic [3:0]      merged_be;
  logic            in_accept;
  logic            out_accept;

  assign in_ready  = (state_q == ST_PACK) && (!out_valid_q || out_ready);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_be    = out_be_q;
  assign out_idx   = out_idx_q;
  assign busy      = (state_q != ST_IDLE);
  assign done      = done_q;
  assign err       = err_q;

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    eew_sum     = {1'b0, vsew} + {1'b0, widening};
    eew_illegal = (eew_sum > 3'd2);
    in_accept   = in_valid && in_ready;
    out_accept  = out_valid_q && out_ready;
    last_elem   = (cnt_q == (vl_q - VL_W'(1)));

    // EPW = 4 >> EEW: slot = cnt mod EPW, byte offset = slot << EEW,
    // word index = cnt / EPW.
    case (eew_q)
      2'd0: begin
        byte_off  = cnt_q[1:0];
        slot_last = (cnt_q[1:0] == 2'd3);
        elem_mask = 32'h0000_00FF;
        elem_be   = 4'b0001;
        word_idx  = cnt_q >> 2;
      end
      2'd1: begin
        byte_off  = {cnt_q[0], 1'b0};
        slot_last = cnt_q[0];
        elem_mask = 32'h0000_FFFF;
        elem_be   = 4'b0011;
        word_idx  = cnt_q >> 1;
      end
      default: begin
        byte_off  = 2'd0;
        slot_last = 1'b1;
        elem_mask = 32'hFFFF_FFFF;
        elem_be   = 4'b1111;
        word_idx  = cnt_q;
      end
    endcase

    merged_data = pack_data_q | ((in_data & elem_mask) << {byte_off, 3'b000});
    merged_be   = pack_be_q | (elem_be << byte_off);

    state_d     = state_q;
    eew_d       = eew_q;
    vl_d        = vl_q;
    cnt_d       = cnt_q;
    pack_data_d = pack_data_q;
    pack_be_d   = pack_be_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_be_d    = out_be_q;
    out_idx_d   = out_idx_q;
    done_d      = 1'b0;
    err_d       = err_q;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          err_d = eew_illegal;
          if ((vl == '0) || eew_illegal) begin
            // Nothing to pack: complete immediately.
            done_d = 1'b1;
          end else begin
            state_d     = ST_PACK;
            eew_d       = eew_sum[1:0];
            vl_d        = vl;
            cnt_d       = '0;
            pack_data_d = '0;
            pack_be_d   = '0;
          end
        end
      end

      ST_PACK: begin
        if (out_accept) begin
          out_valid_d = 1'b0;
        end
        if (in_accept) begin
          cnt_d = cnt_q + VL_W'(1);
          if (slot_last || last_elem) begin
            // in_ready guarantees the output register is free (or being
            // drained on this same edge), so the word can move straight in.
            out_data_d  = merged_data;
            out_be_d    = merged_be;
            out_idx_d   = word_idx;
            out_valid_d = 1'b1;
            pack_data_d = '0;
            pack_be_d   = '0;
          end else begin
            pack_data_d = merged_data;
            pack_be_d   = merged_be;
          end
          if (last_elem) begin
            state_d = ST_DRAIN;
          end
        end
      end

      ST_DRAIN: begin
        if (out_accept) begin
          out_valid_d = 1'b0;
          state_d     = ST_IDLE;
          done_d      = 1'b1;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge value of its _d, independent of statement order.
  always_ff @(posedge clk) begin
    if (!n_reset) begin
      state_q     <= ST_IDLE;
      eew_q       <= 2'd0;
      vl_q        <= '0;
      cnt_q       <= '0;
      pack_data_q <= '0;
      pack_be_q   <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_be_q    <= '0;
      out_idx_q   <= '0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      eew_q       <= eew_d;
      vl_q        <= vl_d;
      cnt_q       <= cnt_d;
      pack_data_q <= pack_data_d;
      pack_be_q   <= pack_be_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_be_q    <= out_be_d;
      out_idx_q   <= out_idx_d;
      done_q      <= done_d;
      err_q       <= err_d;
    end
  end

endmodule

// File: tb/tb_pe_wb_packer.sv
// ---------------------------------------------------------------------------
// tb_pe_wb_packer
//   Directed bench for pe_wb_packer. A table of per-cycle vectors (inputs
//   plus expected outputs) is applied one row per clock; inputs change 1 ns
//   after the rising edge and outputs are compared on the falling edge.
//   A hand-written sequence then runs a longer instruction with irregular
//   in_valid/out_ready and checks the delivered words against constants.
// ---------------------------------------------------------------------------
module tb_pe_wb_packer;

  logic        clk;
  logic        n_reset;
  logic        start;
  logic [6:0]  vl;
  logic [1:0]  vsew;
  logic [1:0]  widening;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [3:0]  out_be;
  logic [6:0]  out_idx;
  logic        busy;
  logic        done;
  logic        err;

  int n_checks = 0;
  int n_errors = 0;

  pe_wb_packer #(.VL_W(7)) dut (
    .clk       (clk),
    .n_reset   (n_reset),
    .start     (start),
    .vl        (vl),
    .vsew      (vsew),
    .widening  (widening),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_be    (out_be),
    .out_idx   (out_idx),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rn;
    logic        st;
    logic [6:0]  vl;
    logic [1:0]  sew;
    logic [1:0]  wid;
    logic        iv;
    logic [31:0] d;
    logic        ordy;
    logic        e_rdy;
    logic        e_ov;
    logic [31:0] e_data;
    logic [3:0]  e_be;
    logic [6:0]  e_idx;
    logic        e_busy;
    logic        e_done;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t v(
    input logic rn, input logic st, input logic [6:0] vl_i,
    input logic [1:0] sew, input logic [1:0] wid, input logic iv,
    input logic [31:0] d, input logic ordy,
    input logic e_rdy, input logic e_ov, input logic [31:0] e_data,
    input logic [3:0] e_be, input logic [6:0] e_idx,
    input logic e_busy, input logic e_done, input logic e_err);
    vec_t r;
    r.rn = rn; r.st = st; r.vl = vl_i; r.sew = sew; r.wid = wid;
    r.iv = iv; r.d = d; r.ordy = ordy;
    r.e_rdy = e_rdy; r.e_ov = e_ov; r.e_data = e_data; r.e_be = e_be;
    r.e_idx = e_idx; r.e_busy = e_busy; r.e_done = e_done; r.e_err = e_err;
    return r;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_table();
    // Columns: rn st vl sew wid iv data ordy | rdy ov data be idx busy done err
    // Reset state.
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,0,0));
    // 8-bit elements, vl=6 (upper in_data bits must be ignored).
    vecs.push_back(v(1,1,6,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h11,1,          1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'hFFFFFF12,1,    1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h13,1,          1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h14,1,          1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h15,1,          1,1,32'h14131211,4'hF,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h16,1,          1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,1,32'h00001615,4'h3,1,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,1,0));
    // EEW=1 via widening, vl=3.
    vecs.push_back(v(1,1,3,0,1,0,32'h0,1,           0,0,32'h0,4'h0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h1234AAAA,1,    1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h5678BBBB,1,    1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h9ABCCCCC,1,    1,1,32'hBBBBAAAA,4'hF,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,1,32'h0000CCCC,4'h3,1,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,1,0));
    // Illegal EEW=3: no ready, err held, done one cycle after start.
    vecs.push_back(v(1,1,5,1,2,0,32'h0,1,           0,0,32'h0,4'h0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h55,1,          0,0,32'h0,4'h0,0,0,1,1));
    vecs.push_back(v(1,0,0,0,0,1,32'h55,1,          0,0,32'h0,4'h0,0,0,0,1));
    // vl=0: done next cycle, err cleared by the accepted start.
    vecs.push_back(v(1,1,0,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,0,1));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,1,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,0,0));
    // 32-bit elements, vl=4, 5-cycle output stall with starts while busy.
    vecs.push_back(v(1,1,4,2,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'hA0000001,1,    1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,1,0,0,0,1,32'hA0000002,0,    0,1,32'hA0000001,4'hF,0,1,0,0));
    vecs.push_back(v(1,1,0,1,2,1,32'hA0000002,0,    0,1,32'hA0000001,4'hF,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'hA0000002,0,    0,1,32'hA0000001,4'hF,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'hA0000002,0,    0,1,32'hA0000001,4'hF,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'hA0000002,0,    0,1,32'hA0000001,4'hF,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'hA0000002,1,    1,1,32'hA0000001,4'hF,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'hA0000003,1,    1,1,32'hA0000002,4'hF,1,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           1,1,32'hA0000003,4'hF,2,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'hA0000004,1,    1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,1,32'hA0000004,4'hF,3,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,1,0));
    // Reset after 2 of 4 elements: back to IDLE, no word, no done.
    vecs.push_back(v(1,1,4,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h01,1,          1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h02,1,          1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(0,0,0,0,0,0,32'h0,1,           1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h03,1,          0,0,32'h0,4'h0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,0,0));
    // Single-element word after reset (pack register must be clean),
    // with a one-cycle stall in DRAIN.
    vecs.push_back(v(1,1,1,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,0,0));
    vecs.push_back(v(1,0,0,0,0,1,32'h0000AB77,1,    1,0,32'h0,4'h0,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,0,           0,1,32'h00000077,4'h1,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,1,32'h00000077,4'h1,0,1,0,0));
    vecs.push_back(v(1,0,0,0,0,0,32'h0,1,           0,0,32'h0,4'h0,0,0,1,0));
  endtask

  task automatic run_table();
    foreach (vecs[i]) begin
      @(posedge clk);
      #1;
      n_reset   = vecs[i].rn;
      start     = vecs[i].st;
      vl        = vecs[i].vl;
      vsew      = vecs[i].sew;
      widening  = vecs[i].wid;
      in_valid  = vecs[i].iv;
      in_data   = vecs[i].d;
      out_ready = vecs[i].ordy;
      @(negedge clk);
      check($sformatf("row%0d in_ready", i),  in_ready,  vecs[i].e_rdy);
      check($sformatf("row%0d out_valid", i), out_valid, vecs[i].e_ov);
      check($sformatf("row%0d busy", i),      busy,      vecs[i].e_busy);
      check($sformatf("row%0d done", i),      done,      vecs[i].e_done);
      check($sformatf("row%0d err", i),       err,       vecs[i].e_err);
      if (vecs[i].e_ov) begin
        check($sformatf("row%0d out_data", i), out_data, vecs[i].e_data);
        check($sformatf("row%0d out_be", i),   out_be,   vecs[i].e_be);
        check($sformatf("row%0d out_idx", i),  out_idx,  vecs[i].e_idx);
      end
    end
  endtask

  // 8-bit elements 0x30..0x38 (vl=9) under irregular handshakes.
  task automatic run_irregular();
    logic [31:0] exp_w [3];
    logic [3:0]  exp_b [3];
    int          sent;
    int          got;
    bit          seen_done;
    exp_w[0] = 32'h33323130; exp_b[0] = 4'hF;
    exp_w[1] = 32'h37363534; exp_b[1] = 4'hF;
    exp_w[2] = 32'h00000038; exp_b[2] = 4'h1;
    sent = 0;
    got = 0;
    seen_done = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b1; vl = 7'd9; vsew = 2'd0; widening = 2'd0;
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int cyc = 0; cyc < 300 && !seen_done; cyc++) begin
      in_valid  = (sent < 9) && ($urandom_range(0, 2) != 0);
      in_data   = in_valid ? (32'hEEEEEE30 + 32'(sent)) : 32'hDEADBEEF;
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clk);
      if (out_valid && out_ready) begin
        if (got < 3) begin
          check($sformatf("irr word%0d data", got), out_data, exp_w[got]);
          check($sformatf("irr word%0d be", got),   out_be,   exp_b[got]);
          check($sformatf("irr word%0d idx", got),  out_idx,  got);
        end
        got++;
      end
      if (in_valid && in_ready) sent++;
      if (done) seen_done = 1'b1;
      @(posedge clk);
      #1;
    end
    check("irr words delivered", got, 3);
    check("irr elements accepted", sent, 9);
    check("irr done seen", {31'd0, seen_done}, 1);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  initial begin
    n_reset   = 1'b0;
    start     = 1'b0;
    vl        = '0;
    vsew      = '0;
    widening  = '0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset out_data", out_data, 0);
    check("reset out_be", out_be, 0);
    check("reset out_idx", out_idx, 0);
    check("reset out_valid", out_valid, 0);
    check("reset in_ready", in_ready, 0);

    fill_table();
    run_table();
    run_irregular();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
